// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter.
//   N_REQ        number of requesters
//   IDX_W        width of a requester index
//   arb_state_e  arbiter FSM states (IDLE, GRANT, RELEASE)
//   idx2onehot   index -> one-hot grant vector
//   next_ptr     owner index -> next search start (wraps 7 -> 0)
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  function automatic logic [N_REQ-1:0] idx2onehot(input logic [IDX_W-1:0] i);
    return N_REQ'(1) << i;
  endfunction

  // Index arithmetic is modulo 2**IDX_W, so 7 + 1 naturally wraps to 0.
  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] i);
    return i + IDX_W'(1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority search, purely combinational.
//   req    [N_REQ-1:0]  request vector
//   ptr    [IDX_W-1:0]  index with highest priority this round
//   idx    [IDX_W-1:0]  first requester found searching upward from ptr
//   found               high when any request bit is set
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ptr + IDX_W'(k);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter with hold-time limit.
//   MAX_HOLD   maximum grant length in cycles (1..255); 0 disables timeout
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   enable     low forces no grant (and revokes a current grant)
//   req[7:0]   request vector
//   done       owner releases the resource (looked at only while granted)
//   gnt[7:0]   registered one-hot grant
//   gnt_idx    registered owner index, 0 when no grant
//   gnt_valid  registered, high when gnt is nonzero
//   timeout    one-cycle pulse when a grant is revoked by the hold limit
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam bit         HOLD_EN  = (MAX_HOLD != 0);
  localparam logic [8:0] HOLD_LIM = 9'(MAX_HOLD);

  arb_state_e       state;
  logic [IDX_W-1:0] ptr;
  logic [7:0]       hold_cnt;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic [8:0]       cnt_plus1;
  logic             hold_hit;
  logic             release_cond;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  rr_pick u_pick (
    .req   (req),
    .ptr   (ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // hold_cnt counts completed GRANT cycles before the current one, so the
  // current cycle is number hold_cnt+1; reaching MAX_HOLD ends the grant
  // after exactly MAX_HOLD cycles of visible gnt.
  always_comb begin
    cnt_plus1    = {1'b0, hold_cnt} + 9'd1;
    hold_hit     = HOLD_EN && (cnt_plus1 >= HOLD_LIM);
    release_cond = done || !req[gnt_idx] || !enable || hold_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && pick_found) begin
            state     <= GRANT;
            gnt       <= idx2onehot(pick_idx);
            gnt_idx   <= pick_idx;
            gnt_valid <= 1'b1;
            hold_cnt  <= '0;
          end
        end
        GRANT: begin
          if (release_cond) begin
            state     <= RELEASE;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            ptr       <= next_ptr(gnt_idx);
            // A done in the same cycle wins: this is a normal release.
            timeout   <= hold_hit && !done;
          end else begin
            hold_cnt <= sat_inc(hold_cnt);
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
module tb_rr_arbiter8;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] req = '0;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_chk = 0;
  int n_fail = 0;

  rr_arbiter8 #(.MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [7:0] r;
    logic       d;
    logic [7:0] exp_gnt;
    logic       exp_to;
  } vec_t;

  vec_t tbl[$];

  // Reference model: owner (-1 = none), idle cycles still owed after a
  // release, cycles held so far, next search start.
  int m_owner, m_cool, m_held, m_ptr;
  bit m_to;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string name, input logic [7:0] eg, input logic eto);
    logic [2:0] ei;
    ei = '0;
    for (int i = 0; i < 8; i++) if (eg[i]) ei = 3'(i);
    chk({name, ".gnt"}, gnt, eg);
    chk({name, ".idx"}, {5'd0, gnt_idx}, {5'd0, ei});
    chk({name, ".valid"}, {7'd0, gnt_valid}, {7'd0, (eg != 0)});
    chk({name, ".timeout"}, {7'd0, timeout}, {7'd0, eto});
  endtask

  // Drive inputs, let one rising edge happen, then sample 1ns later.
  task automatic step(input logic en, input logic [7:0] r, input logic d);
    enable = en; req = r; done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_owner = -1; m_cool = 0; m_held = 0; m_ptr = 0; m_to = 1'b0;
  endtask

  task automatic model_update(input logic en, input logic [7:0] r, input logic d);
    bit expire;
    m_to = 1'b0;
    if (m_owner >= 0) begin
      m_held++;
      expire = (MH != 0) && (m_held >= MH);
      if (d || !r[m_owner] || !en || expire) begin
        m_to    = expire && !d;
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
        m_cool  = 1;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (en && r != 0) begin
      for (int k = 7; k >= 0; k--)
        if (r[(m_ptr + k) % 8]) m_owner = (m_ptr + k) % 8;
      m_held = 0;
    end
  endtask

  task automatic model_step(input logic en, input logic [7:0] r, input logic d);
    step(en, r, d);
    model_update(en, r, d);
    chk_out("rand", (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00, m_to);
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] tmp;

    // Rotation with req all ones and done on each grant's first cycle.
    for (int g = 0; g < 9; g++) begin
      tmp = 8'(1 << (g % 8));
      tbl.push_back('{1'b1, 8'hFF, 1'b0, tmp, 1'b0});
      tbl.push_back('{1'b1, 8'hFF, 1'b1, 8'h00, 1'b0});
      tbl.push_back('{1'b1, 8'hFF, 1'b0, 8'h00, 1'b0});
    end
    // Last owner 0 -> ptr 1; grant 2 to move ptr to 3, then wrap-around skip.
    tbl.push_back('{1'b1, 8'h04, 1'b0, 8'h04, 1'b0});
    tbl.push_back('{1'b1, 8'h04, 1'b1, 8'h00, 1'b0});
    tbl.push_back('{1'b1, 8'h04, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{1'b1, 8'h05, 1'b0, 8'h01, 1'b0});
    tbl.push_back('{1'b1, 8'h05, 1'b1, 8'h00, 1'b0});
    tbl.push_back('{1'b1, 8'h05, 1'b0, 8'h00, 1'b0});

    // Reset state with all requests pending.
    rst_n = 1'b0; enable = 1'b1; req = 8'hFF; done = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk_out("reset", 8'h00, 1'b0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].r, tbl[i].d);
      chk_out($sformatf("tbl%0d", i), tbl[i].exp_gnt, tbl[i].exp_to);
    end

    // Timeout: req[2] held, done low -> four grant cycles, then revoke.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      step(1'b1, 8'h04, 1'b0);
      chk_out($sformatf("to_hold%0d", c), 8'h04, 1'b0);
    end
    step(1'b1, 8'h04, 1'b0);
    chk_out("to_revoke", 8'h00, 1'b1);
    step(1'b1, 8'hFF, 1'b0);
    chk_out("to_release", 8'h00, 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    chk_out("to_next", 8'h08, 1'b0);

    // done in the same cycle the hold limit is reached.
    do_reset();
    for (int c = 0; c < 4; c++) step(1'b1, 8'h01, 1'b0);
    chk_out("sim_held", 8'h01, 1'b0);
    step(1'b1, 8'h01, 1'b1);
    chk_out("sim_rel", 8'h00, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    chk_out("sim_regrant", 8'h01, 1'b0);

    // Non-owner req changes are ignored; enable drop revokes and blocks.
    do_reset();
    step(1'b1, 8'h02, 1'b0);
    chk_out("en_grant", 8'h02, 1'b0);
    step(1'b1, 8'hFB, 1'b0);
    chk_out("nonowner", 8'h02, 1'b0);
    step(1'b0, 8'hFF, 1'b0);
    chk_out("en_drop", 8'h00, 1'b0);
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 8'hFF, 1'b0);
      chk_out($sformatf("en_low%0d", c), 8'h00, 1'b0);
    end
    step(1'b1, 8'hFF, 1'b0);
    chk_out("en_ptr", 8'h04, 1'b0);

    // Asynchronous reset mid-grant drops the grant at once, no timeout.
    #3 rst_n = 1'b0;
    #1 chk_out("async_rst", 8'h00, 1'b0);

    // Randomized run against the reference model.
    do_reset();
    r = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) < 3) r = 8'($urandom());
      model_step(($urandom_range(0, 9) != 0), r, ($urandom_range(0, 4) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
